// File: rtl/bpm_tick_gen.sv
// BPM-driven subdivision/beat/bar tick generator; the tick period comes from a sequential restoring divider.
// Optional swing (alternating long/short intervals) is compiled in by defining BPM_TICK_SWING_EN.
module bpm_tick_gen #(
   parameter int  CLK_HZ        = 50000000,
   parameter int  BPM_W         = 9,
   parameter int  MAX_BPM       = 300,
   parameter int  DEFAULT_BPM   = 120,
   parameter int  SUBDIV        = 4,
   parameter int  BEATS_PER_BAR = 4,
   parameter int  CNT_W         = 32,
   localparam int SUB_W         = (SUBDIV > 1) ? $clog2(SUBDIV) : 1,
   localparam int BEAT_W        = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [BPM_W-1:0]  bpm_in,
   input  logic              load,
   input  logic              run,
`ifdef BPM_TICK_SWING_EN
   input  logic [3:0]        swing_amt,
`endif
   output logic              busy,
   output logic              err,
   output logic              tick,
   output logic              beat,
   output logic              bar,
   output logic [SUB_W-1:0]  sub_idx,
   output logic [BEAT_W-1:0] beat_idx
);

   localparam int                BIT_W          = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   localparam logic [63:0]       DIVIDEND_64    = 64'(CLK_HZ) * 64'd60;
   localparam logic [63:0]       DEFAULT_Q_64   = DIVIDEND_64 / (64'(DEFAULT_BPM) * 64'(SUBDIV));
   localparam logic [CNT_W-1:0]  DIVIDEND       = DIVIDEND_64[CNT_W-1:0];
   localparam logic [CNT_W-1:0]  MIN_PERIOD     = CNT_W'(2);
   localparam logic [CNT_W-1:0]  DEFAULT_PERIOD = (DEFAULT_Q_64 < 64'd2) ? MIN_PERIOD : DEFAULT_Q_64[CNT_W-1:0];
   localparam logic [CNT_W-1:0]  SUBDIV_C       = CNT_W'(SUBDIV);
   localparam logic [BPM_W-1:0]  MAX_BPM_C      = BPM_W'(MAX_BPM);
   localparam logic [SUB_W-1:0]  SUB_LAST       = SUB_W'(SUBDIV - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST      = BEAT_W'(BEATS_PER_BAR - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST       = BIT_W'(CNT_W - 1);

   typedef enum logic {S_IDLE, S_DIV} state_t;

   state_t              r_state, w_state_nxt;
   logic [CNT_W-1:0]    r_period, r_divisor, r_rem, r_quo, r_cnt;
   logic [BIT_W-1:0]    r_bit;
   logic                r_err, r_tick, r_beat, r_bar;
   logic [SUB_W-1:0]    r_sub_nxt, r_sub_out, w_sub_adv;
   logic [BEAT_W-1:0]   r_beat_nxt, r_beat_out, w_beat_adv;
   logic                w_load_ok, w_bpm_bad, w_last, w_ge;
   logic [CNT_W:0]      w_trial, w_diff;
   logic [CNT_W-1:0]    w_rem_nxt, w_quo_nxt, w_interval;

   assign w_load_ok = load && (r_state == S_IDLE);
   assign w_bpm_bad = (bpm_in == '0) || (bpm_in > MAX_BPM_C);
   assign w_last    = (r_bit == BIT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: default assigned first so every path drives w_state_nxt and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_load_ok && !w_bpm_bad) w_state_nxt = S_DIV;
         S_DIV:   if (w_last) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // One restoring step: the borrow out of trial-divisor decides the quotient bit.
   always_comb begin
      w_trial   = {r_rem, r_quo[CNT_W-1]};
      w_diff    = w_trial - {1'b0, r_divisor};
      w_ge      = !w_diff[CNT_W];
      w_rem_nxt = w_ge ? w_diff[CNT_W-1:0] : w_trial[CNT_W-1:0];
      w_quo_nxt = {r_quo[CNT_W-2:0], w_ge};
   end

   // NOTE: divider datapath has no reset; it is always loaded before use and reset aborts through r_state.
   always_ff @(posedge clk) begin
      if (w_load_ok && !w_bpm_bad) begin
         r_divisor <= CNT_W'(bpm_in) * SUBDIV_C;
         r_rem     <= '0;
         r_quo     <= DIVIDEND;
         r_bit     <= '0;
      end else if (r_state == S_DIV) begin
         r_rem <= w_rem_nxt;
         r_quo <= w_quo_nxt;
         r_bit <= r_bit + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_period <= DEFAULT_PERIOD;
         r_err    <= 1'b0;
      end else begin
         if (w_load_ok) r_err <= w_bpm_bad;
         if (r_state == S_DIV && w_last)
            r_period <= (w_quo_nxt < MIN_PERIOD) ? MIN_PERIOD : w_quo_nxt;
      end
   end

   always_comb begin
      w_sub_adv  = (r_sub_nxt == SUB_LAST) ? '0 : r_sub_nxt + 1'b1;
      w_beat_adv = r_beat_nxt;
      if (r_sub_nxt == SUB_LAST)
         w_beat_adv = (r_beat_nxt == BEAT_LAST) ? '0 : r_beat_nxt + 1'b1;
   end

`ifdef BPM_TICK_SWING_EN
   localparam bit SWING_OK = (SUBDIV % 2) == 0;

   logic [3:0]       w_amt;
   logic [CNT_W+3:0] w_prod;
   logic [CNT_W-1:0] r_off;

   always_comb begin
      w_amt  = (swing_amt > 4'd12) ? 4'd12 : swing_amt;
      w_prod = '0;
      for (int k = 0; k < 4; k++)
         if (w_amt[k]) w_prod = w_prod + ({4'b0000, r_period} << k);
   end

   always_ff @(posedge clk) begin
      if (reset) r_off <= '0;
      else       r_off <= CNT_W'(w_prod >> 4);
   end

   // Parity of the index the new interval ends on selects the long or short half.
   always_comb begin
      w_interval = r_period;
      if (SWING_OK) w_interval = w_sub_adv[0] ? (r_period + r_off) : (r_period - r_off);
   end
`else
   assign w_interval = r_period;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_tick     <= 1'b0;
         r_beat     <= 1'b0;
         r_bar      <= 1'b0;
         r_sub_nxt  <= '0;
         r_sub_out  <= '0;
         r_beat_nxt <= '0;
         r_beat_out <= '0;
      end else begin
         r_tick <= 1'b0;
         r_beat <= 1'b0;
         r_bar  <= 1'b0;
         if (!run) begin
            r_cnt      <= '0;
            r_sub_nxt  <= '0;
            r_sub_out  <= '0;
            r_beat_nxt <= '0;
            r_beat_out <= '0;
         end else if (r_cnt == '0) begin
            r_tick     <= 1'b1;
            r_beat     <= (r_sub_nxt == '0);
            r_bar      <= (r_sub_nxt == '0) && (r_beat_nxt == '0);
            r_sub_out  <= r_sub_nxt;
            r_beat_out <= r_beat_nxt;
            r_sub_nxt  <= w_sub_adv;
            r_beat_nxt <= w_beat_adv;
            r_cnt      <= w_interval - 1'b1;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign busy     = (r_state == S_DIV);
   assign err      = r_err;
   assign tick     = r_tick;
   assign beat     = r_beat;
   assign bar      = r_bar;
   assign sub_idx  = r_sub_out;
   assign beat_idx = r_beat_out;

endmodule

// File: doc/bpm_tick_gen.md
Name: bpm_tick_gen

Overview:
- Parametrised successor to the fixed quarter/eighth beat enables; one block replaces all variants.
- Generates subdivision ticks plus beat and bar markers from a runtime BPM value.
- The tick period is computed in hardware as floor(CLK_HZ*60 / (bpm*SUBDIV)) using a sequential restoring divider, so no combinational divide is needed.
- Feeds the sequencer/note-playback logic.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BPM_W, 9, width of bpm_in.
- MAX_BPM, 300, largest accepted BPM.
- DEFAULT_BPM, 120, BPM in effect after reset.
- SUBDIV, 4, ticks per beat (>=1).
- BEATS_PER_BAR, 4, beats per bar (>=1).
- CNT_W, 32, divider/counter width; must satisfy 2^CNT_W > CLK_HZ*60.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- bpm_in, in, BPM_W, requested BPM, sampled on load.
- load, in, 1, single-cycle request to compute a new period.
- run, in, 1, level; 1 = generate ticks, 0 = hold phase at bar start.
- busy, out, 1, divider in progress.
- err, out, 1, sticky: last load was rejected.
- tick, out, 1, one-cycle pulse per subdivision.
- beat, out, 1, pulse coincident with tick when sub_idx==0.
- bar, out, 1, pulse coincident with tick when sub_idx==0 and beat_idx==0.
- sub_idx, out, clog2(SUBDIV) (min 1), subdivision index of the current or last tick.
- beat_idx, out, clog2(BEATS_PER_BAR) (min 1), beat index of the current or last tick.

Behaviour:
- Reset (clk, reset: synchronous, active-high): tick/beat/bar/busy/err = 0; sub_idx = beat_idx = 0; period = floor(CLK_HZ*60/(DEFAULT_BPM*SUBDIV)), computed at elaboration; phase counter cnt = 0. Reset aborts any division in flight.
- Load acceptance: load is accepted only when busy==0.
  - If bpm_in==0 or bpm_in>MAX_BPM: err<=1 next cycle, period unchanged, no division.
  - Otherwise: err<=0, divisor <= bpm_in*SUBDIV, busy<=1 next cycle.
  - load while busy is ignored; err is unchanged.
- Divider FSM (IDLE -> DIV -> IDLE):
  - DIV lasts exactly CNT_W cycles, producing one quotient bit per cycle (MSB first, restoring) with dividend CLK_HZ*60.
  - On the last DIV cycle the quotient, clamped to a minimum of 2, is written to period; busy drops the following cycle.
  - The result is truncated, not rounded.
- Tick counter:
  - run==0: cnt<=0, sub_idx<=0, beat_idx<=0, no pulses.
  - run==1 and cnt==0: tick (plus beat/bar where applicable) pulses next cycle with the current indices; cnt<=period-1; indices then advance, with sub_idx wrapping at SUBDIV-1 and carrying into beat_idx, which wraps at BEATS_PER_BAR-1.
  - run==1 and cnt!=0: cnt<=cnt-1.
- Timing: the first tick pulses 1 cycle after run is first seen high, with bar=beat=1. Subsequent ticks are exactly period cycles apart.
- Period update: a new period takes effect at the next reload (cnt==0). The interval in progress completes with the old period, and phase/indices are preserved. Division may run while run==1.
- run falling mid-interval: the next run start restarts at bar position 0.
- Simultaneous reset and load: reset wins.

Optional Feature:
- Macro: BPM_TICK_SWING_EN.
- Enabled:
  - Adds input swing_amt[3:0]; values >12 are treated as 12.
  - off = (period*swing_amt)>>4, recomputed by shift-add when period updates or swing_amt changes (takes effect at the next reload).
  - Interval ending on an odd sub_idx = period+off; interval ending on an even sub_idx = period-off.
  - Applies only when SUBDIV is even; otherwise ignored.
- Disabled: no port; all intervals equal period.

Test Plan:
- CLK_HZ=1000, CNT_W=16, SUBDIV=4, reset, run=1 -> period 125; first tick 1 cycle after run with bar=beat=1; then ticks every 125 cycles; beat every 500; bar every 2000.
- load with bpm_in=100 mid-interval -> busy high exactly 16 cycles; current interval remains 125; following intervals are 150; sub_idx/beat_idx continue without jump.
- load with bpm_in=0, then bpm_in=301 -> err=1 each time; period stays 125. A subsequent load of 60 -> err=0, period 250.
- load asserted again while busy -> ignored; final period reflects the first load only. reset mid-DIV -> busy=0, period 125.
- run dropped at sub_idx=2, reasserted -> first tick 1 cycle later with sub_idx=0, beat_idx=0, bar=1.
- BPM_TICK_SWING_EN, swing_amt=4, period 125 -> off=31; intervals alternate 156 (into sub 1/3) and 94 (into sub 0/2); swing_amt=15 behaves as 12 (off=93).
